// File: rtl/round_fp_pipe.sv
// rtl/round_fp_pipe.sv - two-stage FP round-and-pack with valid/ready, flush and sticky fflags (optional flags: ROUND_FP_FLAGS_EN)
module round_fp_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     nan_in,
    input  logic                     nv_in,
    input  logic                     inf1,
    input  logic                     inf2,
    input  logic                     sign1,
    input  logic                     sign2,
    input  logic                     sign_res,
    input  logic [EXP_W+1:0]         exp_norm,
    input  logic [MAN_W-1:0]         mantissa_norm,
    input  logic [2:0]               grs,
    input  logic [2:0]               rm,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [4:0]               fflags,
    output logic [4:0]               fflags_acc,
    input  logic                     fflags_clr
);

    typedef enum logic [2:0] {
        K_NAN  = 3'd0,
        K_INF  = 3'd1,
        K_ZERO = 3'd2,
        K_OVF  = 3'd3,
        K_NORM = 3'd4
    } kind_t;

    localparam logic [EXP_W+1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

    logic s1_valid, s2_valid;
    logic s1_adv, s2_adv;

    assign s2_adv    = !s2_valid | out_ready;
    assign s1_adv    = !s1_valid | s2_adv;
    assign in_ready  = s1_adv & !flush;
    assign out_valid = s2_valid;

    logic             any_grs;
    logic             inc;
    logic             ovf_max;
    logic [MAN_W:0]   man_inc;
    logic [EXP_W+1:0] exp_inc;
    kind_t            c_kind;
    logic             c_sign;
    logic [4:0]       c_flags;

    always_comb begin
        any_grs = |grs;
        case (rm)
            3'b000:  inc = grs[2] & (grs[1] | grs[0] | mantissa_norm[0]);
            3'b010:  inc = sign_res & any_grs;
            3'b011:  inc = !sign_res & any_grs;
            3'b100:  inc = grs[2];
            default: inc = 1'b0;
        endcase

        // Carry out of the fraction leaves it all zeros and bumps the exponent.
        man_inc = {1'b0, mantissa_norm} + {{MAN_W{1'b0}}, inc};
        exp_inc = exp_norm + {{(EXP_W+1){1'b0}}, man_inc[MAN_W]};

        case (rm)
            3'b001:  ovf_max = 1'b1;
            3'b010:  ovf_max = !sign_res;
            3'b011:  ovf_max = sign_res;
            default: ovf_max = 1'b0;
        endcase

        c_kind  = K_NORM;
        c_sign  = sign_res;
        c_flags = {4'b0000, any_grs};
        if (rm > 3'b100) begin
            c_kind  = K_NAN;
            c_flags = 5'b10000;
        end else if (nan_in) begin
            c_kind  = K_NAN;
            c_flags = {nv_in, 4'b0000};
        end else if (inf1 && inf2 && (sign1 != sign2)) begin
            c_kind  = K_NAN;
            c_flags = 5'b10000;
        end else if (inf1 || inf2) begin
            c_kind  = K_INF;
            c_sign  = inf1 ? sign1 : sign2;
            c_flags = 5'b00000;
        end else if (exp_norm == '0) begin
            c_kind  = K_ZERO;
            c_flags = {3'b000, {2{(|mantissa_norm) | any_grs}}};
        end else if (exp_norm >= EXP_MAX || exp_inc == EXP_MAX) begin
            c_kind  = K_OVF;
            c_flags = 5'b00101;
        end
    end

    kind_t            s1_kind;
    logic             s1_sign;
    logic             s1_max;
    logic [EXP_W-1:0] s1_exp;
    logic [MAN_W-1:0] s1_man;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_kind  <= K_ZERO;
            s1_sign  <= 1'b0;
            s1_max   <= 1'b0;
            s1_exp   <= '0;
            s1_man   <= '0;
        end else begin
            if (flush)
                s1_valid <= 1'b0;
            else if (s1_adv)
                s1_valid <= in_valid;
            if (in_ready && in_valid) begin
                s1_kind <= c_kind;
                s1_sign <= c_sign;
                s1_max  <= ovf_max;
                s1_exp  <= exp_inc[EXP_W-1:0];
                s1_man  <= man_inc[MAN_W-1:0];
            end
        end
    end

    logic [EXP_W+MAN_W:0] pack;

    always_comb begin
        case (s1_kind)
            K_NAN:   pack = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            K_INF:   pack = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            K_ZERO:  pack = {s1_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            K_OVF:   pack = s1_max ? {s1_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                                   : {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            default: pack = {s1_sign, s1_exp, s1_man};
        endcase
    end

    logic s2_load;
    assign s2_load = s2_adv & s1_valid & !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            result   <= '0;
        end else begin
            if (flush)
                s2_valid <= 1'b0;
            else if (s2_adv)
                s2_valid <= s1_valid;
            if (s2_load)
                result <= pack;
        end
    end

`ifdef ROUND_FP_FLAGS_EN
    logic [4:0] s1_flags;
    logic [4:0] flags_q;
    logic [4:0] acc_q;
    logic       xfer;

    // A result leaving during a flush cycle is being killed, so it does not count.
    assign xfer       = s2_valid & out_ready & !flush;
    assign fflags     = flags_q;
    assign fflags_acc = acc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_flags <= '0;
            flags_q  <= '0;
            acc_q    <= '0;
        end else begin
            if (in_ready && in_valid)
                s1_flags <= c_flags;
            if (s2_load)
                flags_q <= s1_flags;
            if (fflags_clr)
                acc_q <= xfer ? flags_q : 5'b00000;
            else if (xfer)
                acc_q <= acc_q | flags_q;
        end
    end
`else
    assign fflags     = 5'b00000;
    assign fflags_acc = 5'b00000;
    wire unused_flags = &{1'b0, c_flags, fflags_clr};
`endif

endmodule

// File: tb/tb_round_fp_pipe.sv
// tb/tb_round_fp_pipe.sv - directed vector bench for round_fp_pipe
module tb_round_fp_pipe;

`ifdef ROUND_FP_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic        clk, reset_n;
    logic        in_valid, in_ready;
    logic        nan_in, nv_in, inf1, inf2, sign1, sign2, sign_res;
    logic [9:0]  exp_norm;
    logic [22:0] mantissa_norm;
    logic [2:0]  grs, rm;
    logic        flush, out_valid, out_ready, fflags_clr;
    logic [31:0] result;
    logic [4:0]  fflags, fflags_acc;

    round_fp_pipe dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .nan_in(nan_in), .nv_in(nv_in), .inf1(inf1), .inf2(inf2),
        .sign1(sign1), .sign2(sign2), .sign_res(sign_res), .exp_norm(exp_norm),
        .mantissa_norm(mantissa_norm), .grs(grs), .rm(rm), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .fflags(fflags), .fflags_acc(fflags_acc), .fflags_clr(fflags_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        sgn;
        logic [9:0]  e;
        logic [22:0] m;
        logic [2:0]  g;
        logic [2:0]  r;
        logic        i1, i2, s1, s2, nan, nv;
        logic [31:0] res;
        logic [4:0]  fl;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sgn, input logic [9:0] e, input logic [22:0] m,
                                input logic [2:0] g, input logic [2:0] r,
                                input logic i1, input logic i2, input logic s1, input logic s2,
                                input logic nan, input logic nv,
                                input logic [31:0] res, input logic [4:0] fl);
        vec_t v;
        v = '{sgn, e, m, g, r, i1, i2, s1, s2, nan, nv, res, fl};
        return v;
    endfunction

    function automatic logic [4:0] xfl(input logic [4:0] f);
        return FLAGS_ON ? f : 5'b00000;
    endfunction

    task automatic drive(input vec_t v);
        sign_res = v.sgn; exp_norm = v.e; mantissa_norm = v.m; grs = v.g; rm = v.r;
        inf1 = v.i1; inf2 = v.i2; sign1 = v.s1; sign2 = v.s2; nan_in = v.nan; nv_in = v.nv;
    endtask

    vec_t vecs[18];
    vec_t bp[4];

    task automatic apply(input int i);
        @(negedge clk);
        drive(vecs[i]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
        chk($sformatf("vec%0d result", i), result, vecs[i].res);
        chk($sformatf("vec%0d fflags", i), {27'd0, fflags}, {27'd0, xfl(vecs[i].fl)});
    endtask

    logic [31:0] got[$];
    int          k;
    logic [4:0]  acc_before;
    logic        saw_valid;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; fflags_clr = 1'b0;
        drive('0);

        //       sgn e    m         grs     rm      i1 i2 s1 s2 nan nv  result        flags
        vecs[0]  = mk(0, 127, 23'h000001, 3'b100, 3'b000, 0, 0, 0, 0, 0, 0, 32'h3F800002, 5'b00001);
        vecs[1]  = mk(0, 127, 23'h000000, 3'b100, 3'b000, 0, 0, 0, 0, 0, 0, 32'h3F800000, 5'b00001);
        vecs[2]  = mk(0, 127, 23'h000000, 3'b101, 3'b000, 0, 0, 0, 0, 0, 0, 32'h3F800001, 5'b00001);
        vecs[3]  = mk(0, 127, 23'h7FFFFF, 3'b110, 3'b000, 0, 0, 0, 0, 0, 0, 32'h40000000, 5'b00001);
        vecs[4]  = mk(0, 300, 23'h000000, 3'b000, 3'b001, 0, 0, 0, 0, 0, 0, 32'h7F7FFFFF, 5'b00101);
        vecs[5]  = mk(0, 300, 23'h000000, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 32'h7F800000, 5'b00101);
        vecs[6]  = mk(0, 300, 23'h000000, 3'b000, 3'b010, 0, 0, 0, 0, 0, 0, 32'h7F7FFFFF, 5'b00101);
        vecs[7]  = mk(0, 254, 23'h7FFFFF, 3'b100, 3'b000, 0, 0, 0, 0, 0, 0, 32'h7F800000, 5'b00101);
        vecs[8]  = mk(0, 127, 23'h000000, 3'b000, 3'b000, 1, 1, 0, 1, 0, 0, 32'h7FC00000, 5'b10000);
        vecs[9]  = mk(0, 127, 23'h000000, 3'b000, 3'b101, 0, 0, 0, 0, 0, 0, 32'h7FC00000, 5'b10000);
        vecs[10] = mk(1,   0, 23'h000010, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 32'h80000000, 5'b00011);
        vecs[11] = mk(0, 128, 23'h400000, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 32'h40400000, 5'b00000);
        vecs[12] = mk(1, 300, 23'h000000, 3'b000, 3'b011, 0, 0, 0, 0, 0, 0, 32'hFF7FFFFF, 5'b00101);
        vecs[13] = mk(1, 127, 23'h000000, 3'b001, 3'b010, 0, 0, 0, 0, 0, 0, 32'hBF800001, 5'b00001);
        vecs[14] = mk(0, 127, 23'h000000, 3'b100, 3'b100, 0, 0, 0, 0, 0, 0, 32'h3F800001, 5'b00001);
        vecs[15] = mk(0, 127, 23'h000000, 3'b000, 3'b000, 0, 1, 0, 1, 0, 0, 32'hFF800000, 5'b00000);
        vecs[16] = mk(0, 127, 23'h000000, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0, 32'h7FC00000, 5'b00000);
        vecs[17] = mk(0, 127, 23'h000005, 3'b111, 3'b001, 0, 0, 0, 0, 0, 0, 32'h3F800005, 5'b00001);

        bp[0] = mk(0, 127, 23'h000000, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 32'h3F800000, 5'b00000);
        bp[1] = mk(0, 127, 23'h000001, 3'b001, 3'b000, 0, 0, 0, 0, 0, 0, 32'h3F800001, 5'b00001);
        bp[2] = mk(0,   0, 23'h000001, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 32'h00000000, 5'b00011);
        bp[3] = mk(0, 300, 23'h000000, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 32'h7F800000, 5'b00101);

        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset fflags", {27'd0, fflags}, 32'd0);
        chk("reset fflags_acc", {27'd0, fflags_acc}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("in_ready after reset", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 18; i++) apply(i);

        // Drain, then clear the accumulator with no transfer in flight.
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        fflags_clr = 1'b1;
        @(negedge clk);
        fflags_clr = 1'b0;
        #1;
        chk("acc after clear", {27'd0, fflags_acc}, 32'd0);

        // Backpressure: out_ready held low for the first 5 cycles.
        k = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = (c >= 5);
            if (k < 4) begin
                drive(bp[k]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 2) begin
                chk("bp in_ready stalled", {31'd0, in_ready}, 32'd0);
                chk("bp accepted before stall", k, 2);
            end
            if (out_valid && out_ready) got.push_back(result);
            if (in_valid && in_ready) k++;
        end
        chk("bp output count", got.size(), 4);
        for (int j = 0; j < 4; j++)
            chk($sformatf("bp order %0d", j), (j < got.size()) ? got[j] : 32'hDEADBEEF, bp[j].res);
        chk("bp fflags_acc", {27'd0, fflags_acc}, {27'd0, xfl(5'b00111)});

        // Flush with both stages full.
        acc_before = fflags_acc;
        @(negedge clk);
        out_ready = 1'b0;
        drive(bp[1]); in_valid = 1'b1;
        @(negedge clk);
        drive(bp[3]);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b1;
        #1;
        chk("flush out_valid before", {31'd0, out_valid}, 32'd1);
        chk("flush in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush out_valid after", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        saw_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        chk("flush s1 emptied", {31'd0, saw_valid}, 32'd0);
        chk("flush acc unchanged", {27'd0, fflags_acc}, {27'd0, acc_before});
        chk("acc nonzero before reset", {27'd0, fflags_acc}, {27'd0, xfl(5'b00111)});

        // Asynchronous reset in the middle of a cycle.
        @(negedge clk);
        drive(vecs[0]); in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("async reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("async reset fflags_acc", {27'd0, fflags_acc}, 32'd0);
        chk("async reset result", result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        apply(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
